// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Hazard-controller bundle: pipeline status in, hold/flush out.
//  Revision    : 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_branch_taken;
    logic             ex_mdu_start;
    logic             mdu_done;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       state;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, ex_mdu_start, mdu_done, dmem_req, dmem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mem_wb_flush, mem_err, stall_cycles,
               state
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, ex_mdu_start, mdu_done, dmem_req, dmem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mem_wb_flush, mem_err, stall_cycles,
               state
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : 5-stage pipeline hold/bubble/flush sequencer with stall
//                counter and data-memory timeout flag.
//  Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  wire logic     clk,
    input  wire logic     rstn,
    hazard_ctrl_if.master bus
);
    localparam int                c_wcnt_w        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wcnt_w-1:0] c_timeout_last = c_wcnt_w'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max       = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic                r_saved_mdu, w_saved_mdu_nxt;
    logic [c_wcnt_w-1:0] r_wait_cnt,  w_wait_cnt_nxt;
    logic                r_mem_err,   w_mem_err_nxt;
    logic [CNT_W-1:0]    r_stall_cycles;

    logic w_memfreeze;
    logic w_loaduse;
    logic w_mdu_mode;
    logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall;
    logic w_id_ex_flush, w_ex_mem_stall, w_ex_mem_flush, w_mem_wb_flush;

    assign w_memfreeze = bus.dmem_req & ~bus.dmem_ready;
    assign w_loaduse   = bus.ex_memread & (bus.ex_rd != 5'd0) &
                         ((bus.id_use_rs1 & (bus.ex_rd == bus.id_rs1)) |
                          (bus.id_use_rs2 & (bus.ex_rd == bus.id_rs2)));
    // Once a freeze lifts, MEM_WAIT behaves exactly like the state it interrupted.
    assign w_mdu_mode  = (r_state == ST_MDU_WAIT) ||
                         ((r_state == ST_MEM_WAIT) && r_saved_mdu);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= ST_RUN;
            r_saved_mdu    <= 1'b0;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_saved_mdu <= w_saved_mdu_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_err   <= w_mem_err_nxt;
            if (w_pc_stall && (r_stall_cycles != c_cnt_max)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_saved_mdu_nxt = r_saved_mdu;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_mem_err_nxt   = r_mem_err;
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_stall  = 1'b0;
        w_ex_mem_flush  = 1'b0;
        w_mem_wb_flush  = 1'b0;

        if (w_memfreeze) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
            w_mem_wb_flush = 1'b1;
            if (r_wait_cnt == c_timeout_last) begin
                w_mem_err_nxt   = 1'b1;
                w_wait_cnt_nxt  = '0;
                w_state_nxt     = ST_RUN;
                w_saved_mdu_nxt = 1'b0;
            end else begin
                w_wait_cnt_nxt  = r_wait_cnt + 1'b1;
                w_state_nxt     = ST_MEM_WAIT;
                // A completion seen during the freeze is consumed; the MDU holds it.
                w_saved_mdu_nxt = w_mdu_mode & ~bus.mdu_done;
            end
        end else begin
            w_wait_cnt_nxt  = '0;
            w_saved_mdu_nxt = 1'b0;
            if (w_mdu_mode) begin
                if (bus.mdu_done) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_state_nxt    = ST_MDU_WAIT;
                end
            end else begin
                w_state_nxt = ST_RUN;
                if (bus.ex_branch_taken) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (bus.ex_mdu_start && !bus.mdu_done) begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_stall  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_state_nxt    = ST_MDU_WAIT;
                end else if (w_loaduse) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
        end

        if (!rstn) begin
            w_pc_stall     = 1'b0;
            w_if_id_stall  = 1'b0;
            w_if_id_flush  = 1'b0;
            w_id_ex_stall  = 1'b0;
            w_id_ex_flush  = 1'b0;
            w_ex_mem_stall = 1'b0;
            w_ex_mem_flush = 1'b0;
            w_mem_wb_flush = 1'b0;
        end
    end

    assign bus.pc_stall     = w_pc_stall;
    assign bus.if_id_stall  = w_if_id_stall;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_stall  = w_id_ex_stall;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.ex_mem_stall = w_ex_mem_stall;
    assign bus.ex_mem_flush = w_ex_mem_flush;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.mem_err      = r_mem_err;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.state        = r_state;
endmodule
`default_nettype wire
